// File: rtl/serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial add/sub controller.
// master = requester side, slave = controller side.
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clr;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, sub, a, b, clr,
        input  ready, busy, done, sum, c_out, overflow
    );

    modport slave (
        input  start, sub, a, b, clr,
        output ready, busy, done, sum, c_out, overflow
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller time-sharing one full-adder cell, LSB first.
// Latency: start edge E0, bits at E1..E_WIDTH, done pulse the cycle after E_WIDTH.
// Backpressure: start is taken only while ready=1; starts in RUN/DONE are ignored.

module serial_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_adder_ctrl_if.slave  ctl
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_s;
    logic             fa_co;

    serial_fa u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            carry   <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            r_sh    <= '0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ctl.clr) begin
            // Abort keeps the last completed result visible.
            state   <= IDLE;
            cnt     <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ctl.start) begin
                        a_sh    <= ctl.a;
                        b_sh    <= ctl.sub ? ~ctl.b : ctl.b;
                        carry   <= ctl.sub;
                        cnt     <= '0;
                        state   <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
                    r_sh  <= {fa_s, r_sh[WIDTH-1:1]};
                    carry <= fa_co;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        // carry here is the MSB carry-in, so this XOR is signed overflow.
                        sum_q   <= {fa_s, r_sh[WIDTH-1:1]};
                        c_out_q <= fa_co;
                        ovf_q   <= fa_co ^ carry;
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ctl.ready    = ready_q;
    assign ctl.busy     = busy_q;
    assign ctl.done     = done_q;
    assign ctl.sum      = sum_q;
    assign ctl.c_out    = c_out_q;
    assign ctl.overflow = ovf_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed vector table, multi-cycle corner sequences
// (ignored starts, clr abort, async reset) and random ops against an arithmetic model.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    serial_adder_ctrl_if #(.WIDTH(W)) io ();

    serial_adder_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_sum;
        logic         exp_co;
        logic         exp_ov;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", nm, got, exp);
        end
    endtask

    // Reference arithmetic from plain integer math.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] sm, output logic co, output logic ov);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ur = s ? ua - ub : ua + ub;
        sr = s ? sa - sb : sa + sb;
        sm = W'(ur);
        co = s ? (ua >= ub) : (ur > (1 << W) - 1);
        ov = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    endfunction

    // Called just after a negedge. Samples/drives only on negedges.
    // poke_k: pulse start (a=AA) at that RUN cycle; clr_k: assert clr then; poke_done: pulse start while done.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                          input int poke_k, input int clr_k, input bit poke_done,
                          output int done_k, output int done_n, output int busy_n, output int rdy_bad);
        done_k  = -1;
        done_n  = 0;
        busy_n  = 0;
        rdy_bad = 0;
        io.a     = ia;
        io.b     = ib;
        io.sub   = isub;
        io.start = 1'b1;
        for (int k = 1; k <= W + 4; k++) begin
            @(negedge clk);
            io.start = 1'b0;
            io.clr   = 1'b0;
            io.a     = ~ia;
            io.b     = ~ib;
            io.sub   = ~isub;
            if (io.busy) busy_n++;
            if ((io.busy || io.done) && io.ready) rdy_bad++;
            if (io.done) begin
                done_n++;
                if (done_k < 0) done_k = k - 1;
                if (poke_done) begin
                    io.start = 1'b1;
                    io.a     = 8'hAA;
                end
            end
            if (k == poke_k) begin
                io.start = 1'b1;
                io.a     = 8'hAA;
            end
            if (k == clr_k) io.clr = 1'b1;
        end
        io.start = 1'b0;
        io.clr   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         vecs[5];
        int           dk, dn, bn, rb;
        logic [W-1:0] ms;
        logic         mc, mo;
        logic [W-1:0] ra, rbv;
        logic         rs;

        checks   = 0;
        failures = 0;
        vecs[0] = '{1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};

        rst_n    = 1'b0;
        io.start = 1'b0;
        io.sub   = 1'b0;
        io.a     = '0;
        io.b     = '0;
        io.clr   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(io.ready), 32'd1);
        chk("rst_busy", 32'(io.busy), 32'd0);
        chk("rst_done", 32'(io.done), 32'd0);
        chk("rst_sum", 32'(io.sum), 32'd0);
        chk("rst_cout_ovf", {30'd0, io.c_out, io.overflow}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, -1, -1, 1'b0, dk, dn, bn, rb);
            chk($sformatf("vec%0d_sum", i), 32'(io.sum), 32'(vecs[i].exp_sum));
            chk($sformatf("vec%0d_cout", i), 32'(io.c_out), 32'(vecs[i].exp_co));
            chk($sformatf("vec%0d_ovf", i), 32'(io.overflow), 32'(vecs[i].exp_ov));
            chk($sformatf("vec%0d_latency", i), 32'(dk), 32'(W));
            chk($sformatf("vec%0d_done_cnt", i), 32'(dn), 32'd1);
            chk($sformatf("vec%0d_busy_cnt", i), 32'(bn), 32'(W));
            chk($sformatf("vec%0d_ready_hs", i), 32'(rb), 32'd0);
        end

        // Starts during RUN and DONE must be ignored.
        run_op(8'h01, 8'h01, 1'b0, 3, -1, 1'b1, dk, dn, bn, rb);
        chk("ign_sum", 32'(io.sum), 32'h02);
        chk("ign_busy_cnt", 32'(bn), 32'(W));
        chk("ign_done_cnt", 32'(dn), 32'd1);
        chk("ign_idle_after", {30'd0, io.ready, io.busy}, 32'b10);

        // clr mid-RUN: no done, previous result kept.
        run_op(8'h5A, 8'h3C, 1'b0, -1, -1, 1'b0, dk, dn, bn, rb);
        chk("clr_pre_sum", 32'(io.sum), 32'h96);
        run_op(8'h11, 8'h22, 1'b0, -1, 4, 1'b0, dk, dn, bn, rb);
        chk("clr_done_cnt", 32'(dn), 32'd0);
        chk("clr_busy_cnt", 32'(bn), 32'd4);
        chk("clr_sum_kept", 32'(io.sum), 32'h96);
        chk("clr_ready", 32'(io.ready), 32'd1);
        run_op(8'h11, 8'h22, 1'b0, -1, -1, 1'b0, dk, dn, bn, rb);
        chk("clr_next_sum", 32'(io.sum), 32'h33);
        chk("clr_next_done", 32'(dn), 32'd1);

        // Async reset mid-RUN, applied between edges.
        io.a     = 8'hF0;
        io.b     = 8'h0F;
        io.sub   = 1'b0;
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        repeat (2) @(negedge clk);
        chk("arst_pre_busy", 32'(io.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(io.ready), 32'd1);
        chk("arst_busy", 32'(io.busy), 32'd0);
        chk("arst_sum", 32'(io.sum), 32'd0);
        chk("arst_cout_ovf_done", {29'd0, io.c_out, io.overflow, io.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h03, 8'h04, 1'b0, -1, -1, 1'b0, dk, dn, bn, rb);
        chk("arst_next_sum", 32'(io.sum), 32'h07);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra  = W'($urandom);
            rbv = W'($urandom);
            rs  = 1'($urandom_range(0, 1));
            model(ra, rbv, rs, ms, mc, mo);
            run_op(ra, rbv, rs, -1, -1, 1'b0, dk, dn, bn, rb);
            chk($sformatf("rnd%0d_sum a=%0h b=%0h sub=%0d", i, ra, rbv, rs), 32'(io.sum), 32'(ms));
            chk($sformatf("rnd%0d_flags a=%0h b=%0h sub=%0d", i, ra, rbv, rs),
                {30'd0, io.c_out, io.overflow}, {30'd0, mc, mo});
            chk($sformatf("rnd%0d_latency", i), 32'(dk), 32'(W));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
